// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined CPU front end:
//   - default datapath widths (instruction, opcode, word-addressed PC)
//   - opcode enumeration decoded by the control unit
//   - fetch_entry_t, one buffered fetch result {instr, pc}
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_INSTRWIDTH  = 24;
    localparam int CPU_OPCODEWIDTH = 4;
    localparam int CPU_PCWIDTH     = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_STORE = 4'b0001,
        OP_MOVI  = 4'b0010,
        OP_MOV   = 4'b0011,
        OP_OUT   = 4'b0100,
        OP_ADD   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_LOAD  = 4'b0111,
        OP_AND   = 4'b1000,
        OP_SHIFT = 4'b1001,
        OP_CMP   = 4'b1010,
        OP_BEQ   = 4'b1011,
        OP_JR    = 4'b1100,
        OP_BGT   = 4'b1101,
        OP_JMP   = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic [CPU_INSTRWIDTH-1:0] instr;
        logic [CPU_PCWIDTH-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry synchronous FIFO holding fetched {instr, pc} entries. Slot 0 is
// always the head, so the head output is a plain register read.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   clear_i        flush all entries at the next edge (wins over push/pop)
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          discard the head entry
//   count_o        occupancy 0..2
//   head_o         head entry (meaningful only when count_o != 0)
// Handshake: push is accepted when not full or when a pop happens in the same
// cycle; pop is accepted only when not empty. Requests that cannot be
// accepted are ignored.
// -----------------------------------------------------------------------------
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       push_i,
    input  entry_t     push_data_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output entry_t     head_o
);

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;
    logic       do_push;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);

        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = push_data_i;
                    end else begin
                        slot1_d = push_data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Head advances; the new entry lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        slot0_d = push_data_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign count_o = count_q;
    assign head_o  = slot0_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: generates the PC, issues instruction-memory reads, buffers the
// returned words in a 2-entry FIFO and presents the head to decode.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   imemReqF       read request this cycle (combinational)
//   imemAddrF      word address of the request (combinational)
//   imemDataF      read data, valid exactly one cycle after the request
//   stallD         decode cannot accept; hold the head
//   redirectE      taken jump/branch: flush and refetch from redirectPCE
//   redirectPCE    redirect target
//   validD         head holds a real instruction
//   instrD         head instruction, 0 when !validD
//   opcodeD        head opcode field, NOP when !validD
//   pcD            head address, 0 when !validD
// Handshake: decode consumes the head in any cycle with validD=1, stallD=0 and
// no redirect. A request is only issued when the word it returns is certain
// to have a free FIFO slot; a redirect always issues and discards everything
// older.
// -----------------------------------------------------------------------------
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                OPCODEWIDTH = CPU_OPCODEWIDTH,
    parameter int                INSTRWIDTH  = CPU_INSTRWIDTH,
    parameter int                PCWIDTH     = CPU_PCWIDTH,
    parameter logic [PCWIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imemReqF,
    output logic [PCWIDTH-1:0]     imemAddrF,
    input  logic [INSTRWIDTH-1:0]  imemDataF,
    input  logic                   stallD,
    input  logic                   redirectE,
    input  logic [PCWIDTH-1:0]     redirectPCE,
    output logic                   validD,
    output logic [INSTRWIDTH-1:0]  instrD,
    output logic [OPCODEWIDTH-1:0] opcodeD,
    output logic [PCWIDTH-1:0]     pcD
);

    typedef struct packed {
        logic [INSTRWIDTH-1:0] instr;
        logic [PCWIDTH-1:0]    pc;
    } entry_t;

    logic [PCWIDTH-1:0] pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [PCWIDTH-1:0] req_addr_q, req_addr_d;

    logic [1:0] count;
    entry_t     head;
    entry_t     push_data;
    logic       pop;
    logic       push;
    logic       clear;
    logic [2:0] committed;
    logic       credit;

    always_comb begin
        pop       = (count != 2'd0) && !stallD && !redirectE;
        // Slots that will be taken once the in-flight word lands and the head
        // (if popped) leaves; a new request needs one more free slot.
        committed = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        credit    = committed < 3'd2;

        imemReqF  = !rst && (redirectE || credit);
        imemAddrF = redirectE ? redirectPCE : pc_q;

        // A word returning during a redirect belongs to the abandoned stream.
        push      = inflight_q && !redirectE && !rst;
        push_data = '{instr: imemDataF, pc: req_addr_q};
        clear     = redirectE;

        pc_d       = pc_q;
        if (redirectE) begin
            pc_d = redirectPCE + PCWIDTH'(1);
        end else if (imemReqF) begin
            pc_d = pc_q + PCWIDTH'(1);
        end
        inflight_d = imemReqF;
        req_addr_d = imemAddrF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_buffer #(
        .entry_t (entry_t)
    ) u_fetch_buffer (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    // Empty FIFO presents an all-zero NOP so decode emits no controls.
    always_comb begin
        validD  = (count != 2'd0);
        instrD  = validD ? head.instr : '0;
        opcodeD = validD ? head.instr[INSTRWIDTH-1 -: OPCODEWIDTH] : OPCODEWIDTH'(OP_NOP);
        pcD     = validD ? head.pc : '0;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch: directed reset/latency/stall/
// redirect/wrap/mid-stream-reset scenarios followed by random stall, redirect
// and reset traffic, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        redirectE;
    logic [15:0] redirectPCE;
    logic [23:0] imemDataF;
    logic        imemReqF;
    logic [15:0] imemAddrF;
    logic        validD;
    logic [23:0] instrD;
    logic [3:0]  opcodeD;
    logic [15:0] pcD;

    logic [23:0] imemDataF_w;
    logic        imemReqF_w;
    logic [15:0] imemAddrF_w;
    logic        validD_w;
    logic [23:0] instrD_w;
    logic [3:0]  opcodeD_w;
    logic [15:0] pcD_w;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [39:0] exp_q[$];
    bit          m_infl;
    logic [15:0] m_infl_addr;
    logic [23:0] m_infl_data;
    logic [15:0] m_pc;
    bit          chk_en;
    bit          mem_mode;

    // Memory environment state
    bit          prev_req;
    logic [15:0] prev_addr;
    bit          prev_req_w;
    logic [15:0] prev_addr_w;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imemReqF    (imemReqF),
        .imemAddrF   (imemAddrF),
        .imemDataF   (imemDataF),
        .stallD      (stallD),
        .redirectE   (redirectE),
        .redirectPCE (redirectPCE),
        .validD      (validD),
        .instrD      (instrD),
        .opcodeD     (opcodeD),
        .pcD         (pcD)
    );

    instruction_fetch #(.RESET_PC(16'hFFFE)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .imemReqF    (imemReqF_w),
        .imemAddrF   (imemAddrF_w),
        .imemDataF   (imemDataF_w),
        .stallD      (1'b0),
        .redirectE   (1'b0),
        .redirectPCE (16'h0000),
        .validD      (validD_w),
        .instrD      (instrD_w),
        .opcodeD     (opcodeD_w),
        .pcD         (pcD_w)
    );

    function automatic logic [23:0] mem_f(input logic [15:0] a);
        if (!mem_mode) return {8'h00, a} + 24'h000100;
        return {a[3:0] ^ a[7:4], 4'hA, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, advance the model,
    // then move to the next falling edge and drive the memory response.
    task automatic cycle();
        int          occ;
        bit          pop;
        bit          req;
        logic [15:0] addr;
        logic [39:0] head;
        #1;
        occ  = exp_q.size();
        head = (occ > 0) ? exp_q[0] : 40'd0;
        if (chk_en) begin
            check_eq("validD", validD, occ > 0);
            check_eq("instrD", instrD, head[39:16]);
            check_eq("opcodeD", opcodeD, head[39:36]);
            check_eq("pcD", pcD, head[15:0]);
        end
        pop  = (occ > 0) && !stallD && !redirectE;
        req  = !rst && (redirectE || ((occ + int'(m_infl) - int'(pop)) < 2));
        addr = redirectE ? redirectPCE : m_pc;
        if (chk_en) begin
            check_eq("imemReqF", imemReqF, req);
            if (req) check_eq("imemAddrF", imemAddrF, addr);
        end
        if (rst) begin
            exp_q.delete();
            m_infl = 0;
            m_pc   = 16'h0000;
            chk_en = 1;
        end else if (redirectE) begin
            exp_q.delete();
            m_infl      = 1;
            m_infl_addr = redirectPCE;
            m_infl_data = mem_f(redirectPCE);
            m_pc        = redirectPCE + 16'd1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (m_infl) exp_q.push_back({m_infl_data, m_infl_addr});
            m_infl = req;
            if (req) begin
                m_infl_addr = m_pc;
                m_infl_data = mem_f(m_pc);
                m_pc        = m_pc + 16'd1;
            end
        end
        prev_req    = imemReqF;
        prev_addr   = imemAddrF;
        prev_req_w  = imemReqF_w;
        prev_addr_w = imemAddrF_w;
        @(posedge clk);
        @(negedge clk);
        imemDataF   = prev_req ? mem_f(prev_addr) : 24'($urandom);
        imemDataF_w = prev_req_w ? mem_f(prev_addr_w) : 24'($urandom);
    endtask

    task automatic do_redirect(input logic [15:0] target, input bit stall);
        stallD      = stall;
        redirectE   = 1'b1;
        redirectPCE = target;
        #1;
        check_eq("redir_req", imemReqF, 1'b1);
        check_eq("redir_addr", imemAddrF, target);
        cycle();
        redirectE = 1'b0;
        stallD    = 1'b0;
        #1;
        check_eq("redir_bubble_valid", validD, 1'b0);
        check_eq("redir_bubble_opcode", opcodeD, 4'b0000);
        cycle();
        #1;
        check_eq("redir_valid", validD, 1'b1);
        check_eq("redir_pcD", pcD, target);
        cycle();
    endtask

    initial begin
        rst         = 1'b1;
        stallD      = 1'b0;
        redirectE   = 1'b0;
        redirectPCE = 16'h0000;
        imemDataF   = 24'h0;
        imemDataF_w = 24'h0;
        mem_mode    = 1'b0;
        chk_en      = 1'b0;
        m_infl      = 0;
        m_pc        = 16'h0000;
        @(negedge clk);
        cycle();

        // Reset state (rst still high)
        #1;
        check_eq("rst_validD", validD, 1'b0);
        check_eq("rst_opcodeD", opcodeD, 4'b0000);
        check_eq("rst_instrD", instrD, 24'h0);
        check_eq("rst_pcD", pcD, 16'h0);
        check_eq("rst_imemReqF", imemReqF, 1'b0);
        check_eq("rst_imemAddrF", imemAddrF, 16'h0000);
        cycle();
        rst = 1'b0;

        // Free run: cycles 0..4, latency and wrap on the second instance
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c == 0) begin
                check_eq("c0_req", imemReqF, 1'b1);
                check_eq("c0_addr", imemAddrF, 16'h0000);
                check_eq("c0_req_w", imemReqF_w, 1'b1);
                check_eq("c0_addr_w", imemAddrF_w, 16'hFFFE);
            end
            if (c == 1) check_eq("c1_valid", validD, 1'b0);
            if (c == 2) begin
                check_eq("c2_valid", validD, 1'b1);
                check_eq("c2_pcD", pcD, 16'h0000);
                check_eq("c2_instrD", instrD, 24'h000100);
                check_eq("wrap_pcD_0", pcD_w, 16'hFFFE);
            end
            if (c == 3) check_eq("wrap_pcD_1", pcD_w, 16'hFFFF);
            if (c == 4) check_eq("wrap_pcD_2", pcD_w, 16'h0000);
            cycle();
        end

        // Stall 5 cycles starting with pcD=3
        stallD = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            check_eq("stall_pcD", pcD, 16'd3);
            check_eq("stall_req", imemReqF, 1'b0);
            cycle();
        end
        stallD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("release_pcD", pcD, 16'(3 + k));
            cycle();
        end

        // Fill to 2 entries, then redirect while stalled
        stallD = 1'b1;
        cycle();
        cycle();
        do_redirect(16'h0040, 1'b1);
        for (int k = 0; k < 3; k++) cycle();

        // Redirect while streaming, and across the address wrap
        do_redirect(16'h1234, 1'b0);
        cycle();
        do_redirect(16'hFFFF, 1'b0);
        for (int k = 0; k < 3; k++) cycle();

        // One-cycle reset mid-stream
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_eq("mrst_valid0", validD, 1'b0);
        check_eq("mrst_req", imemReqF, 1'b1);
        check_eq("mrst_addr", imemAddrF, 16'h0000);
        cycle();
        #1;
        check_eq("mrst_valid1", validD, 1'b0);
        cycle();
        #1;
        check_eq("mrst_valid2", validD, 1'b1);
        check_eq("mrst_pcD", pcD, 16'h0000);
        cycle();

        // Random traffic
        mem_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            stallD      = ($urandom_range(0, 99) < 30);
            redirectE   = ($urandom_range(0, 99) < 8);
            redirectPCE = 16'($urandom);
            rst         = ($urandom_range(0, 99) < 2);
            cycle();
        end
        rst       = 1'b0;
        stallD    = 1'b0;
        redirectE = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
